// File: rtl/mux4to1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4to1_rr_arbiter
//
// Round-robin arbiter that owns the select of a 4:1 single-bit mux. Four
// requesters compete for the shared output. The winner receives a registered
// one-hot grant, the mux select points at it, and its data bit is gated onto f.
// Ownership is limited to MAX_HOLD consecutive cycles whenever another
// requester is waiting, so no requester can starve the others.
//
// Handshake: req[i] is a level request. It stays high for as long as
// requester i wants the channel. gnt[i] high means requester i owns f in the
// current cycle. No request is queued: requests are sampled at the clock edge
// where arbitration happens.
//
// Parameters:
//   MAX_HOLD : maximum consecutive grant cycles per ownership (1..16)
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active high
//   req   : [3:0] request per requester
//   I     : [3:0] mux data inputs, one bit per requester
//   gnt   : [3:0] registered one-hot grant, zero when idle
//   s     : [1:0] registered mux select (current or last owner)
//   valid : registered, high while a grant is active
//   f     : combinational, I[s] when valid, otherwise 0
// ---------------------------------------------------------------------------
module mux4to1_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] I,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       valid,
  output logic       f
);

  // The hold counter needs at least one bit, even when MAX_HOLD is 1 or 2.
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The state register is a named flop so a checker can bind to it.
  state_t           state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Round-robin search. Candidates are s+1, s+2, s+3 and then s itself.
  // Checking the owner last is what rotates it out on a timeout when another
  // requester is waiting.
  logic [1:0] win;
  logic       found;
  logic [1:0] cand;

  always_comb begin
    win   = s_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = s_q + 2'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state logic and registered outputs
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (found) begin
          s_d     = win;
          gnt_d   = 4'b0001 << win;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (req[s_q] && (cnt_q != CNT_LAST)) begin
          // The owner keeps the grant and stays inside its hold budget.
          cnt_d = cnt_q + 1'b1;
        end else if (found) begin
          // This covers a release with a handoff and also a timeout. On a
          // timeout the owner is always found, at the latest as the last
          // candidate, so a lone requester is regranted without a gap.
          s_d   = win;
          gnt_d = 4'b0001 << win;
          cnt_d = '0;
        end else begin
          // Nobody is requesting. The pointer keeps the last owner.
          gnt_d   = 4'b0000;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    endcase

    valid_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 2'd3;  // the first search after reset starts at requester 0
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign valid = valid_q;
  assign f     = valid_q & I[s_q];

endmodule

// File: tb/tb_mux4to1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4to1_rr_arbiter
//
// Two arbiters share one stimulus stream. One uses MAX_HOLD = 4 and the other
// uses MAX_HOLD = 1. Before each clock edge the driver advances an ownership
// model, which tracks the owner, whether the channel is busy and how long the
// current ownership has run. It pushes the expected post-edge outputs of both
// instances into exp_q. A separate monitor pops one entry after every
// rising edge and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_mux4to1_rr_arbiter;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] I;

  always #5 clk = ~clk;

  logic [3:0] gnt4, gnt1;
  logic [1:0] s4, s1;
  logic       valid4, valid1, f4, f1;

  mux4to1_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .I(I),
    .gnt(gnt4), .s(s4), .valid(valid4), .f(f4)
  );

  mux4to1_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .I(I),
    .gnt(gnt1), .s(s1), .valid(valid1), .f(f1)
  );

  // ---------------- scoreboard state ----------------
  // Each entry is {dut1 {gnt,s,valid,f}, dut4 {gnt,s,valid,f}}.
  logic [15:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got gnt=%b s=%0d valid=%b f=%b, expected gnt=%b s=%0d valid=%b f=%b",
               name, $time, act[7:4], act[3:2], act[1], act[0],
               exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks ownership rather than counter encoding. An owner may
  // keep the channel for hold_lim cycles in a row. After that, the next
  // requester in rotation after the owner takes over, and the owner itself
  // is considered last.
  int hold_lim[2] = '{4, 1};
  bit m_busy[2];
  int m_ptr[2];
  int m_run[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 1'b0;
      m_ptr[m]  = 3;
      m_run[m]  = 0;
    end
  endtask

  function automatic int rr_pick(input int from, input logic [3:0] r);
    for (int off = 1; off <= 4; off++) begin
      if (r[(from + off) % 4]) return (from + off) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int m, input logic [3:0] r);
    int w;
    w = rr_pick(m_ptr[m], r);
    if (m_busy[m] && r[m_ptr[m]] && m_run[m] < hold_lim[m]) begin
      m_run[m]++;
    end else if (w >= 0) begin
      m_busy[m] = 1'b1;
      m_ptr[m]  = w;
      m_run[m]  = 1;
    end else begin
      m_busy[m] = 1'b0;
      m_run[m]  = 0;
    end
  endtask

  function automatic logic [7:0] model_out(input int m, input logic [3:0] d);
    logic [3:0] g;
    logic       fv;
    g  = m_busy[m] ? (4'b0001 << m_ptr[m]) : 4'b0000;
    fv = m_busy[m] ? d[m_ptr[m]] : 1'b0;
    return {g, 2'(m_ptr[m]), m_busy[m], fv};
  endfunction

  // ---------------- driver ----------------
  // The driver drives inputs on the falling edge. Those inputs are sampled
  // at the next rising edge and stay stable while the monitor samples.
  task automatic step(input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    req = r;
    I   = d;
    model_step(0, r);
    model_step(1, r);
    exp_q.push_back({model_out(1, d), model_out(0, d)});
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [15:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dut_hold4", {gnt4, s4, valid4, f4}, e[7:0]);
      chk("dut_hold1", {gnt1, s1, valid1, f1}, e[15:8]);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req = 4'b0000;
    I   = 4'hF;
    model_reset();
    #1;
    chk("reset_hold4", {gnt4, s4, valid4, f4}, {4'b0000, 2'd3, 1'b0, 1'b0});
    chk("reset_hold1", {gnt1, s1, valid1, f1}, {4'b0000, 2'd3, 1'b0, 1'b0});

    @(negedge clk);
    rst = 1'b0;

    // Single request from cycle 2. Check f with I set and cleared.
    step(4'b0000, 4'b0100);
    step(4'b0100, 4'b0100);
    step(4'b0100, 4'b0100);
    step(4'b0100, 4'b0000);
    step(4'b0100, 4'b0000);

    // Reset in the middle of a grant to owner 2. The outputs must clear
    // without a clock edge.
    @(negedge clk);
    req = 4'b0000;
    I   = 4'hF;
    #2 rst = 1'b1;
    #1;
    chk("midrst_hold4", {gnt4, s4, valid4, f4}, {4'b0000, 2'd3, 1'b0, 1'b0});
    chk("midrst_hold1", {gnt1, s1, valid1, f1}, {4'b0000, 2'd3, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // All four requesters active. Hold 4 gives runs of four and hold 1
    // rotates every cycle. Both start at requester 0.
    for (int k = 0; k < 20; k++) step(4'b1111, 4'($urandom_range(0, 15)));

    // A lone requester is held beyond its limit, then releases to idle.
    for (int k = 0; k < 10; k++) step(4'b0010, 4'($urandom_range(0, 15)));
    step(4'b0000, 4'hF);
    step(4'b0000, 4'hF);

    // Owner 0 drops its request while requester 2 is waiting.
    step(4'b0001, 4'b0101);
    step(4'b0101, 4'b0101);
    step(4'b0100, 4'b0101);
    step(4'b0100, 4'b0101);

    // Two requesters alternate.
    for (int k = 0; k < 8; k++) step(4'b1010, 4'($urandom_range(0, 15)));

    // Sweep: for every select, try every data pattern.
    for (int k = 0; k < 4; k++)
      for (int d = 0; d < 16; d++)
        step(4'b0001 << k, 4'(d));

    // Random requests, each held for a random number of cycles.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] r;
      int         len;
      r   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) step(r, 4'($urandom_range(0, 15)));
    end

    // Let the monitor drain the last expectation.
    @(posedge clk);
    #2;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
